// File: rtl/fault_list_builder.sv
// Scans the BIST pass map row-major and compacts faulty PE coordinates
// into NUM_RU recompute-unit slots, handed off via valid/ack.
module fault_list_builder #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int NUM_RU = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bist_done,
  input  logic [ROWS*COLS-1:0]     stw_result,
  input  logic                     list_ack,
  output logic                     busy,
  output logic                     list_valid,
  output logic [NUM_RU*((ROWS>1)?$clog2(ROWS):1)-1:0] fault_row,
  output logic [NUM_RU*((COLS>1)?$clog2(COLS):1)-1:0] fault_col,
  output logic [NUM_RU-1:0]        slot_valid,
  output logic [$clog2(NUM_RU+1)-1:0] fault_count,
  output logic [$clog2(ROWS*COLS+1)-1:0] total_faults,
  output logic                     unrepairable
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int NW = $clog2(NUM_RU + 1);
  localparam int TW = $clog2(ROWS * COLS + 1);
  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t               state_q;
  logic [N-1:0]         snap_q;
  logic [IW-1:0]        idx_q;
  logic                 busy_q;
  logic                 list_valid_q;
  logic [NUM_RU*RW-1:0] fault_row_q;
  logic [NUM_RU*CW-1:0] fault_col_q;
  logic [NUM_RU-1:0]    slot_valid_q;
  logic [NW-1:0]        fault_count_q;
  logic [TW-1:0]        total_faults_q;
  logic                 unrepairable_q;

  logic [RW-1:0]        row_d;
  logic [CW-1:0]        col_d;
  logic                 hit_d;
  logic                 last_d;

  always_comb begin
    row_d  = RW'(32'(idx_q) / COLS);
    col_d  = CW'(32'(idx_q) % COLS);
    hit_d  = ~snap_q[idx_q];
    last_d = (idx_q == IW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      snap_q         <= '1;
      idx_q          <= '0;
      busy_q         <= 1'b0;
      list_valid_q   <= 1'b0;
      fault_row_q    <= '0;
      fault_col_q    <= '0;
      slot_valid_q   <= '0;
      fault_count_q  <= '0;
      total_faults_q <= '0;
      unrepairable_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bist_done) begin
            snap_q         <= stw_result;
            idx_q          <= '0;
            fault_row_q    <= '0;
            fault_col_q    <= '0;
            slot_valid_q   <= '0;
            fault_count_q  <= '0;
            total_faults_q <= '0;
            unrepairable_q <= 1'b0;
            busy_q         <= 1'b1;
            state_q        <= SCAN;
          end
        end
        SCAN: begin
          if (hit_d) begin
            total_faults_q <= total_faults_q + TW'(1);
            if (fault_count_q < NW'(NUM_RU)) begin
              for (int k = 0; k < NUM_RU; k++) begin
                if (fault_count_q == NW'(k)) begin
                  fault_row_q[k*RW +: RW] <= row_d;
                  fault_col_q[k*CW +: CW] <= col_d;
                  slot_valid_q[k]         <= 1'b1;
                end
              end
              fault_count_q <= fault_count_q + NW'(1);
            end else begin
              unrepairable_q <= 1'b1;
            end
          end
          idx_q <= idx_q + IW'(1);
          // Fixed-length scan: completion depends only on the index
          if (last_d) begin
            busy_q       <= 1'b0;
            list_valid_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (list_ack) begin
            list_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign list_valid   = list_valid_q;
  assign fault_row    = fault_row_q;
  assign fault_col    = fault_col_q;
  assign slot_valid   = slot_valid_q;
  assign fault_count  = fault_count_q;
  assign total_faults = total_faults_q;
  assign unrepairable = unrepairable_q;

endmodule

// File: doc/fault_list_builder.md
Name: fault_list_builder

Overview:
- Sits between the BIST signature-test-window (STW) result capture and the recompute-unit (RU) controller.
- After BIST completes, it scans the pass/fail map of the ROWS x COLS systolic PE array in row-major order, one PE per cycle.
- It compacts faulty PE coordinates into a list of NUM_RU slots, one slot per recompute unit, and flags arrays with more faults than RUs as unrepairable.
- The list is handed to the RU controller through a valid/ack handshake.

Parameters:
- ROWS, 4, PE array rows.
- COLS, 4, PE array columns.
- NUM_RU, 4, number of recompute units, i.e. list slots.
- Derived localparams (not overridable):
  - RW = max(1, clog2(ROWS)).
  - CW = max(1, clog2(COLS)).
  - NW = clog2(NUM_RU+1).
  - TW = clog2(ROWS*COLS+1).

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- bist_done  in  1  single-cycle pulse; stw_result is valid in the same cycle.
- stw_result  in  ROWS*COLS  pass map; bit r*COLS+c = PE(r,c); 1 = pass, 0 = fault.
- list_ack  in  1  RU controller has consumed the list.
- busy  out  1  high in SCAN.
- list_valid  out  1  list complete and stable.
- fault_row  out  NUM_RU*RW  slot k in bits [k*RW +: RW].
- fault_col  out  NUM_RU*CW  slot k in bits [k*CW +: CW].
- slot_valid  out  NUM_RU  bit k = slot k holds a fault.
- fault_count  out  NW  slots filled, saturates at NUM_RU.
- total_faults  out  TW  all faults found, including those past NUM_RU.
- unrepairable  out  1  total_faults > NUM_RU.

Behaviour:
- Reset (async): state=IDLE; all outputs 0; internal snapshot = all-ones; scan index = 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - bist_done=1 at edge t: latch stw_result into snapshot.
  - Clear slot_valid, fault_row, fault_col, fault_count, total_faults, unrepairable.
  - Set idx=0; go to SCAN.
- SCAN (busy=1): at each edge, examine snapshot[idx], with r=idx/COLS and c=idx%COLS.
  - Bit 0 and fault_count<NUM_RU: write slot[fault_count] = (r,c); set slot_valid[fault_count]; increment fault_count.
  - Bit 0 and fault_count==NUM_RU: no slot write; set unrepairable.
  - Any 0 bit increments total_faults.
  - idx increments every edge. On the edge that processes idx=ROWS*COLS-1, go to DONE.
  - Fixed latency: list_valid rises after edge t+ROWS*COLS, regardless of fault count.
- DONE:
  - list_valid=1; all list outputs held constant.
  - list_ack=1 at an edge: list_valid drops to 0 and FSM returns to IDLE.
  - List contents remain held after the return to IDLE, until the next accepted bist_done.
- bist_done in SCAN or DONE is ignored; there is no queueing. stw_result changes after the capture edge have no effect.
- list_ack outside DONE is ignored.
- Slots are filled in row-major order, so slot 0 holds the lowest-index fault.
- Unused slots: slot_valid bit = 0, row/col = 0.
- Reset mid-SCAN or mid-DONE: immediate return to IDLE with all outputs 0; the partial list is discarded.
- bist_done and list_ack in the same cycle while in DONE: ack wins, FSM goes to IDLE, bist_done is dropped.
- Zero faults: completes with fault_count=0, slot_valid=0, list_valid=1, unrepairable=0.

Test Plan:
- Reset mid-scan:
  - Reset, then check all outputs 0.
  - Pulse bist_done with stw_result=16'hFFFF, then assert rst 5 cycles later.
  - Required: busy=0 and list_valid=0 at once. A later bist_done with 16'hFFFF gives list_valid after 16 cycles with fault_count=0.
- Single fault:
  - stw_result with only bit 6 = 0, i.e. PE(1,2).
  - Required: list_valid exactly 16 cycles after bist_done; slot0=(1,2); slot_valid=4'b0001; fault_count=1; total_faults=1; unrepairable=0.
- Full list:
  - Faults at bits 0, 5, 10, 15.
  - Required: slots (0,0), (1,1), (2,2), (3,3); slot_valid=4'b1111; fault_count=4; unrepairable=0.
- Overflow:
  - Six faults at bits 1, 2, 3, 4, 8, 12.
  - Required: slots (0,1), (0,2), (0,3), (1,0); fault_count=4; total_faults=6; unrepairable=1.
- Handshake:
  - Hold list_ack=0 for 10 cycles in DONE, and pulse bist_done during that time.
  - Required: list stays stable and the bist_done is ignored.
  - Then assert list_ack together with bist_done: list_valid falls, FSM goes to IDLE, no new scan starts, outputs are retained.
- Input change after capture:
  - Toggle stw_result every cycle during SCAN.
  - Required: the result matches the map captured at the bist_done edge.
